// File: rtl/oxi_pkg.sv
// Shared types and helpers for the AFE runtime sequencer: FSM states, channel ids,
// per-channel AFE settings and accumulator width.
package oxi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RED_SETTLE,
        ST_RED_ACQ,
        ST_IR_SETTLE,
        ST_IR_ACQ,
        ST_DARK_SETTLE,
        ST_DARK_ACQ,
        ST_PUBLISH
    } seq_state_t;

    localparam logic [1:0] CH_RED  = 2'd0;
    localparam logic [1:0] CH_IR   = 2'd1;
    localparam logic [1:0] CH_DARK = 2'd2;

    typedef struct packed {
        logic [6:0] dc;
        logic [3:0] pga;
    } afe_cfg_t;

    // Sum of 2^log2_samples 8-bit samples always fits in this many bits.
    function automatic int acc_w(input int log2_samples);
        return 8 + log2_samples;
    endfunction

    function automatic logic [1:0] state_ch(input seq_state_t s);
        case (s)
            ST_RED_SETTLE, ST_RED_ACQ: return CH_RED;
            ST_IR_SETTLE, ST_IR_ACQ:   return CH_IR;
            default:                   return CH_DARK;
        endcase
    endfunction

endpackage

// File: rtl/led_adc_sequencer_phase_accumulator.sv
// Sums 2^LOG2_SAMPLES ADC samples; on the last enabled cycle presents the
// truncated average and a done flag, then rearms itself.
module phase_accumulator
    import oxi_pkg::*;
#(
    parameter int LOG2_SAMPLES = 2
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] adc,
    output logic [7:0] result,
    output logic       done
);
    localparam int ACC_W = acc_w(LOG2_SAMPLES);
    localparam int CNT_W = (LOG2_SAMPLES > 0) ? LOG2_SAMPLES : 1;
    localparam int N     = 1 << LOG2_SAMPLES;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;

    // The current sample is folded in combinationally so the result is ready on the last cycle.
    assign sum    = acc + ACC_W'(adc);
    assign result = sum[LOG2_SAMPLES +: 8];
    assign done   = enable && (cnt == CNT_W'(N - 1));

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (clear || done) begin
            acc <= '0;
            cnt <= '0;
        end else if (enable) begin
            acc <= sum;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_adc_sequencer.sv
// Runtime AFE scheduler: per frame runs RED, IR and DARK phases (settle, then
// average ADC), then publishes the three averages with a one-cycle strobe.
module led_adc_sequencer
    import oxi_pkg::*;
#(
    parameter int SETTLE_CYC   = 4,
    parameter int LOG2_SAMPLES = 2
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] RED_DC_Comp,
    input  logic [3:0] RED_PGA,
    input  logic [6:0] IR_DC_Comp,
    input  logic [3:0] IR_PGA,
    input  logic [7:0] ADC,
    output logic       LED_RED,
    output logic       LED_IR,
    output logic [6:0] DC_Comp,
    output logic [3:0] PGA_Gain,
    output logic [7:0] RED_ADC_Value,
    output logic [7:0] IR_ADC_Value,
    output logic [7:0] DARK_ADC_Value,
    output logic       sample_valid,
    output logic       busy
);
    localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    seq_state_t      state;
    logic [SC_W-1:0] scnt;
    afe_cfg_t        red_cfg, ir_cfg;
    logic [7:0]      hold_red, hold_ir;
    logic            acq, frame_go, settle_end, acc_done;
    logic [7:0]      acc_res;

    assign acq        = state inside {ST_RED_ACQ, ST_IR_ACQ, ST_DARK_ACQ};
    assign frame_go   = start && (state == ST_IDLE || state == ST_PUBLISH);
    assign settle_end = (scnt == SC_W'(SETTLE_CYC - 1));

    phase_accumulator #(.LOG2_SAMPLES(LOG2_SAMPLES)) u_acc (
        .CLK    (CLK),
        .rst_n  (rst_n),
        .clear  (!acq),
        .enable (acq),
        .adc    (ADC),
        .result (acc_res),
        .done   (acc_done)
    );

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            red_cfg <= '0;
            ir_cfg  <= '0;
        end else if (frame_go) begin
            red_cfg <= '{dc: RED_DC_Comp, pga: RED_PGA};
            ir_cfg  <= '{dc: IR_DC_Comp,  pga: IR_PGA};
        end
    end

    // DARK needs no holding register: its result goes straight to the published outputs.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            hold_red <= '0;
            hold_ir  <= '0;
        end else if (acc_done) begin
            if (state_ch(state) == CH_RED) hold_red <= acc_res;
            if (state_ch(state) == CH_IR)  hold_ir  <= acc_res;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            scnt           <= '0;
            LED_RED        <= 1'b0;
            LED_IR         <= 1'b0;
            DC_Comp        <= '0;
            PGA_Gain       <= '0;
            RED_ADC_Value  <= '0;
            IR_ADC_Value   <= '0;
            DARK_ADC_Value <= '0;
            sample_valid   <= 1'b0;
            busy           <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (frame_go) begin
                // Drive from the inputs directly: the latch captures them on this same edge.
                state    <= ST_RED_SETTLE;
                scnt     <= '0;
                LED_RED  <= 1'b1;
                LED_IR   <= 1'b0;
                DC_Comp  <= RED_DC_Comp;
                PGA_Gain <= RED_PGA;
                busy     <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_RED_SETTLE, ST_IR_SETTLE, ST_DARK_SETTLE: begin
                        scnt <= scnt + 1'b1;
                        if (settle_end) begin
                            scnt <= '0;
                            case (state)
                                ST_RED_SETTLE: state <= ST_RED_ACQ;
                                ST_IR_SETTLE:  state <= ST_IR_ACQ;
                                default:       state <= ST_DARK_ACQ;
                            endcase
                        end
                    end
                    ST_RED_ACQ: if (acc_done) begin
                        state    <= ST_IR_SETTLE;
                        LED_RED  <= 1'b0;
                        LED_IR   <= 1'b1;
                        DC_Comp  <= ir_cfg.dc;
                        PGA_Gain <= ir_cfg.pga;
                    end
                    ST_IR_ACQ: if (acc_done) begin
                        state  <= ST_DARK_SETTLE;
                        LED_IR <= 1'b0;
                    end
                    ST_DARK_ACQ: if (acc_done) begin
                        state          <= ST_PUBLISH;
                        RED_ADC_Value  <= hold_red;
                        IR_ADC_Value   <= hold_ir;
                        DARK_ADC_Value <= acc_res;
                        sample_valid   <= 1'b1;
                    end
                    ST_PUBLISH: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state   <= ST_IDLE;
                        scnt    <= '0;
                        LED_RED <= 1'b0;
                        LED_IR  <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_adc_sequencer.sv
// Randomized bench for led_adc_sequencer against a frame-position reference model.
module tb_led_adc_sequencer;
    localparam int S     = 4;
    localparam int L     = 2;
    localparam int N     = 1 << L;
    localparam int PH    = S + N;
    localparam int FRAME = 3 * PH + 1;

    logic       CLK = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [6:0] RED_DC_Comp = '0, IR_DC_Comp = '0;
    logic [3:0] RED_PGA = '0, IR_PGA = '0;
    logic [7:0] ADC = '0;
    logic       LED_RED, LED_IR, sample_valid, busy;
    logic [6:0] DC_Comp;
    logic [3:0] PGA_Gain;
    logic [7:0] RED_ADC_Value, IR_ADC_Value, DARK_ADC_Value;

    led_adc_sequencer #(.SETTLE_CYC(S), .LOG2_SAMPLES(L)) dut (
        .CLK(CLK), .rst_n(rst_n), .start(start),
        .RED_DC_Comp(RED_DC_Comp), .RED_PGA(RED_PGA),
        .IR_DC_Comp(IR_DC_Comp), .IR_PGA(IR_PGA), .ADC(ADC),
        .LED_RED(LED_RED), .LED_IR(LED_IR), .DC_Comp(DC_Comp), .PGA_Gain(PGA_Gain),
        .RED_ADC_Value(RED_ADC_Value), .IR_ADC_Value(IR_ADC_Value),
        .DARK_ADC_Value(DARK_ADC_Value), .sample_valid(sample_valid), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0, n_fail = 0, n_pulse = 0;

    // Model: pos = cycle index within the frame (-1 idle, FRAME-1 publish).
    int pos = -1;
    int sums[3];
    int c_rdc, c_rpga, c_idc, c_ipga;
    int e_dc, e_pga, e_red, e_ir, e_dark;
    bit e_valid;
    int trunc_pat[4] = '{10, 20, 30, 41};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pos = -1;
        sums = '{0, 0, 0};
        {c_rdc, c_rpga, c_idc, c_ipga} = '0;
        {e_dc, e_pga, e_red, e_ir, e_dark} = '0;
        e_valid = 0;
    endtask

    task automatic model_edge();
        e_valid = 0;
        if (pos >= 0 && pos < FRAME - 1 && (pos % PH) >= S) sums[pos / PH] += int'(ADC);
        if (pos == FRAME - 2) begin
            e_red = sums[0] / N; e_ir = sums[1] / N; e_dark = sums[2] / N;
            e_valid = 1;
        end
        if (pos < 0 || pos == FRAME - 1) begin
            if (start) begin
                pos = 0;
                c_rdc = RED_DC_Comp; c_rpga = RED_PGA;
                c_idc = IR_DC_Comp;  c_ipga = IR_PGA;
                sums = '{0, 0, 0};
            end else pos = -1;
        end else pos++;
        if (pos >= 0 && pos < FRAME - 1) begin
            if (pos / PH == 0) begin e_dc = c_rdc; e_pga = c_rpga; end
            else begin e_dc = c_idc; e_pga = c_ipga; end
        end
    endtask

    task automatic check_outs();
        bit in_frame;
        in_frame = (pos >= 0 && pos < FRAME - 1);
        chk("led_red",  LED_RED,        32'(in_frame && pos / PH == 0));
        chk("led_ir",   LED_IR,         32'(in_frame && pos / PH == 1));
        chk("dc_comp",  DC_Comp,        e_dc);
        chk("pga_gain", PGA_Gain,       e_pga);
        chk("busy",     busy,           32'(pos >= 0));
        chk("valid",    sample_valid,   32'(e_valid));
        chk("red_val",  RED_ADC_Value,  e_red);
        chk("ir_val",   IR_ADC_Value,   e_ir);
        chk("dark_val", DARK_ADC_Value, e_dark);
        if (sample_valid === 1'b1) n_pulse++;
    endtask

    function automatic logic [7:0] adc_for(input int mode);
        bit acq;
        int ch;
        acq = (pos >= 0 && pos < FRAME - 1 && (pos % PH) >= S);
        ch  = (pos >= 0) ? pos / PH : 0;
        case (mode)
            0: return !acq ? 8'd200 : (ch == 0) ? 8'd100 : (ch == 1) ? 8'd50 : 8'd10;
            2: return 8'd255;
            3: begin
                if (!acq) return 8'd200;
                if (ch == 0) return 8'(trunc_pat[(pos % PH) - S]);
                return 8'($urandom_range(0, 255));
            end
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic step(input int mode);
        ADC = adc_for(mode);
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check_outs();
    endtask

    initial begin
        int p0;
        model_reset();
        repeat (2) step(1);
        rst_n = 1'b1;
        step(1);

        // Nominal frame from a one-cycle start pulse
        RED_DC_Comp = 7'd40; RED_PGA = 4'd3; IR_DC_Comp = 7'd60; IR_PGA = 4'd5;
        p0 = n_pulse;
        start = 1'b1; step(0); start = 1'b0;
        repeat (FRAME + 4) step(0);
        chk("pulse_once", n_pulse - p0, 1);
        chk("a_red",  RED_ADC_Value,  100);
        chk("a_ir",   IR_ADC_Value,   50);
        chk("a_dark", DARK_ADC_Value, 10);
        chk("a_idle", {LED_RED, LED_IR, busy}, 0);

        // Averaging truncation
        start = 1'b1; step(3); start = 1'b0;
        repeat (FRAME + 1) step(3);
        chk("trunc", RED_ADC_Value, 25);

        // Full scale, back-to-back frames
        p0 = n_pulse;
        start = 1'b1;
        repeat (3 * FRAME) step(2);
        chk("b2b_pulses", n_pulse - p0, 3);
        chk("fs_red",  RED_ADC_Value,  255);
        chk("fs_ir",   IR_ADC_Value,   255);
        chk("fs_dark", DARK_ADC_Value, 255);
        start = 1'b0;
        repeat (3) step(2);

        // Settings change during IR_SETTLE only lands next frame
        RED_DC_Comp = 7'd40;
        start = 1'b1;
        for (int k = 0; k < FRAME && pos != PH; k++) step(1);
        RED_DC_Comp = 7'd90;
        repeat (FRAME - PH) step(1);
        chk("rdc_next", DC_Comp, 90);
        start = 1'b0;
        repeat (FRAME + 2) step(1);

        // Random settings, start and ADC
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) start = ~start;
            RED_DC_Comp = 7'($urandom); RED_PGA = 4'($urandom);
            IR_DC_Comp  = 7'($urandom); IR_PGA  = 4'($urandom);
            step(1);
        end
        start = 1'b0;
        repeat (FRAME + 2) step(1);

        // Asynchronous reset in IR_ACQ aborts the frame
        p0 = n_pulse;
        start = 1'b1; step(1); start = 1'b0;
        for (int k = 0; k < FRAME && pos != PH + S + 1; k++) step(1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outs();
        repeat (3) step(1);
        rst_n = 1'b1;
        repeat (FRAME + 2) step(1);
        chk("rst_no_pulse", n_pulse - p0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led_adc_sequencer.md
Name: led_adc_sequencer

Overview:
Runtime scheduler for the shared analog front end (LED driver, DC compensation DAC, PGA, 8-bit ADC) once calibration has produced per-channel RED/IR settings. Each frame runs three time-multiplexed phases: RED, IR and DARK (ambient, both LEDs off). Each phase applies that channel's DC_Comp/PGA_Gain, waits a settle window, then averages ADC samples. At frame end it publishes all three averages with a one-cycle valid strobe. It sits between the calibration controller (settings source) and the downstream SpO2/filter datapath (sample sink).

Parameters:
SETTLE_CYC, 4, cycles after a phase switch before sampling starts (>=1)
LOG2_SAMPLES, 2, log2 of ADC samples averaged per phase (0..4)

Ports:
CLK  input  1  system clock, all logic on posedge
rst_n  input  1  asynchronous, active-low reset
start  input  1  level; high = run frames continuously
RED_DC_Comp  input  7  calibrated DC comp for RED
RED_PGA  input  4  calibrated PGA gain for RED
IR_DC_Comp  input  7  calibrated DC comp for IR
IR_PGA  input  4  calibrated PGA gain for IR
ADC  input  8  ADC sample, valid every cycle
LED_RED  output  1  RED LED enable
LED_IR  output  1  IR LED enable
DC_Comp  output  7  DC compensation to AFE
PGA_Gain  output  4  PGA gain to AFE
RED_ADC_Value  output  8  averaged RED sample
IR_ADC_Value  output  8  averaged IR sample
DARK_ADC_Value  output  8  averaged ambient sample
sample_valid  output  1  one-cycle strobe: new triple published
busy  output  1  high while a frame is in progress

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is CLK. In reset all outputs are 0, FSM is IDLE, and the accumulator, counters and latched settings are cleared. A reset mid-frame aborts the frame immediately with no valid strobe.
- Settings are latched on the IDLE->RED_SETTLE transition and on PUBLISH->RED_SETTLE. Input changes mid-frame are ignored until the next frame.
- States: IDLE, RED_SETTLE, RED_ACQ, IR_SETTLE, IR_ACQ, DARK_SETTLE, DARK_ACQ, PUBLISH.
- IDLE: LEDs off; DC_Comp/PGA_Gain hold their last value; busy=0. Move to RED_SETTLE when start=1.
- RED_*: LED_RED=1, LED_IR=0, DC_Comp/PGA_Gain = latched RED values.
- IR_*: LED_RED=0, LED_IR=1, DC_Comp/PGA_Gain = latched IR values.
- DARK_*: both LEDs 0, DC_Comp/PGA_Gain = latched IR values.
- Outputs are registered and change on the same edge that enters the phase.
- *_SETTLE lasts exactly SETTLE_CYC cycles, with ADC ignored.
- *_ACQ lasts exactly N=2^LOG2_SAMPLES cycles. The ADC is added each cycle into an accumulator of width 8+LOG2_SAMPLES, which never overflows. The accumulator is cleared on ACQ entry.
- On the last ACQ cycle, the phase result is (acc+ADC)>>LOG2_SAMPLES, truncated and in the range 0..255. It is stored in an internal holding register.
- PUBLISH: lasts 1 cycle. RED/IR/DARK_ADC_Value update together and sample_valid=1 for this cycle only. The outputs hold until the next PUBLISH or reset.
- After PUBLISH: if start=1, go to RED_SETTLE with no gap (back-to-back frames); otherwise go to IDLE.
- start deasserted mid-frame: the current frame completes and publishes, then the FSM returns to IDLE. A start pulse shorter than a frame still yields exactly one frame.
- busy=1 in every state except IDLE.
- Frame length: 3*(SETTLE_CYC+N)+1 cycles. With defaults this is 25 cycles.
- Illegal state encoding recovers to IDLE on the next cycle.

Decomposition:
- Shared package oxi_pkg: state enum/localparams, ACC_W = 8+LOG2_SAMPLES helper, CH_RED/CH_IR/CH_DARK channel constants.
- One sub-module, phase_accumulator: clear, enable, ADC in; averaged 8-bit result plus a done flag after N enables.
- The FSM, settings latch and output registers stay in led_adc_sequencer.

Test Plan:
- Defaults, settings RED=(40,3), IR=(60,5). Drive ADC=100 during RED_ACQ, 50 during IR_ACQ, 10 during DARK_ACQ, and 200 during settle windows. Raise start at cycle 0. Expect sample_valid on cycle 25 only, with RED=100, IR=50, DARK=10 (settle data excluded), and DC_Comp/PGA_Gain = 40/3, then 60/5, then 60/5.
- Averaging truncation: in RED_ACQ, ADC=10,20,30,41. Expect RED_ADC_Value=25.
- Full scale: ADC=255 constant. Expect all three values = 255, with no wrap.
- start high for 1 cycle only. Expect exactly one frame, one valid pulse, then IDLE with LEDs 0 and busy=0. With start held high, expect valid pulses every 25 cycles.
- Change RED_DC_Comp 40->90 during IR_SETTLE. Expect no effect this frame and DC_Comp=90 in the next frame's RED phase.
- Assert rst_n=0 during IR_ACQ. Expect all outputs 0 immediately (asynchronous), no valid pulse, and after release the block stays IDLE until start.
